// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and board defaults.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // 12 MHz board clock divided down to 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 104;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Zero padding to MAX_DATA_BITS leaves the XOR reduction unchanged.
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] word, input int mode);
    return (mode == PARITY_ODD) ? ~^word : ^word;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Ready/valid word handshake between a producer and the UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);

  logic                 i_valid;
  logic [DATA_BITS-1:0] i_data;
  logic                 o_ready;

  modport master (
    output i_valid,
    output i_data,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_data,
    output o_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: one-cycle tick every CLKS_PER_BIT clocks, restartable via clear.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] count;

  // clear restarts the bit period so that frame timing lines up with the handshake
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (count == CNT_W'(CLKS_PER_BIT - 1)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: ready/valid word in, LSB-first framed serial line out.
// Line, busy and done are registered and follow the FSM state by one clock.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  uart_tx_param_if.slave tx_if,
  output logic           o_tx,
  output logic           o_busy,
  output logic           o_done
);

  localparam int BIT_W = $clog2(DATA_BITS + 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state;
  tx_state_t            next_state;
  logic                 handshake;
  logic                 tick;
  logic                 last_bit;
  logic                 last_stop;
  logic                 line_level;
  logic                 par_bit;
  logic [DATA_BITS-1:0] shift;
  logic [BIT_W-1:0]     bit_cnt;

  assign tx_if.o_ready = (state == TX_IDLE) && i_rst_n;
  assign handshake     = tx_if.i_valid && tx_if.o_ready;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .clear(handshake),
    .tick (tick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= TX_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    line_level = 1'b1;
    last_bit   = (bit_cnt == BIT_W'(DATA_BITS - 1));
    last_stop  = (bit_cnt == BIT_W'(STOP_BITS - 1));
    unique case (state)
      TX_IDLE: begin
        if (handshake) begin
          next_state = TX_START;
        end
      end
      TX_START: begin
        line_level = 1'b0;
        if (tick) begin
          next_state = TX_DATA;
        end
      end
      TX_DATA: begin
        line_level = shift[0];
        if (tick && last_bit) begin
          next_state = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: begin
        line_level = par_bit;
        if (tick) begin
          next_state = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tick && last_stop) begin
          next_state = TX_IDLE;
        end
      end
      default: begin
        next_state = TX_IDLE;
      end
    endcase
  end

  // bit_cnt is shared: data bits in DATA, then stop bits in STOP
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shift   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      o_tx    <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_tx   <= line_level;
      o_busy <= (state != TX_IDLE);
      o_done <= (state == TX_STOP) && tick && last_stop;
      if (handshake) begin
        shift   <= tx_if.i_data;
        par_bit <= parity_of(MAX_DATA_BITS'(tx_if.i_data), PARITY);
        bit_cnt <= '0;
      end else if (tick) begin
        case (state)
          TX_DATA: begin
            shift   <= shift >> 1;
            bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
          end
          TX_STOP: begin
            bit_cnt <= last_stop ? '0 : bit_cnt + BIT_W'(1);
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances cover 8N1, 7E1, 7O1 and 8N2 at 4 clocks per bit.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic clk;
  logic rst_n;
  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;
  logic tx_c, busy_c, done_c;
  logic tx_d, busy_d, done_d;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_tx_param_if #(.DATA_BITS(8)) if_a ();
  uart_tx_param_if #(.DATA_BITS(7)) if_b ();
  uart_tx_param_if #(.DATA_BITS(7)) if_c ();
  uart_tx_param_if #(.DATA_BITS(8)) if_d ();

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .tx_if(if_a), .o_tx(tx_a), .o_busy(busy_a), .o_done(done_a)
  );
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .tx_if(if_b), .o_tx(tx_b), .o_busy(busy_b), .o_done(done_b)
  );
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .tx_if(if_c), .o_tx(tx_c), .o_busy(busy_c), .o_done(done_c)
  );
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .tx_if(if_d), .o_tx(tx_d), .o_busy(busy_d), .o_done(done_d)
  );

  logic [3:0] tx_v, busy_v, done_v, ready_v;
  assign tx_v    = {tx_d, tx_c, tx_b, tx_a};
  assign busy_v  = {busy_d, busy_c, busy_b, busy_a};
  assign done_v  = {done_d, done_c, done_b, done_a};
  assign ready_v = {if_d.o_ready, if_c.o_ready, if_b.o_ready, if_a.o_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int d, input logic v, input logic [8:0] w);
    case (d)
      0:       begin if_a.i_valid = v; if_a.i_data = w[7:0]; end
      1:       begin if_b.i_valid = v; if_b.i_data = w[6:0]; end
      2:       begin if_c.i_valid = v; if_c.i_data = w[6:0]; end
      default: begin if_d.i_valid = v; if_d.i_data = w[7:0]; end
    endcase
  endtask

  // Called on a negedge with the DUT idle; ends on the negedge showing o_done.
  task automatic runFrame(input int d, input string tag, input logic [8:0] w, input int nbits,
                          input bit par_on, input logic exp_par, input int stops,
                          input bit hold, input int glitch_k);
    logic line [0:12];
    int   nline;
    int   total;
    line[0] = 1'b0;
    for (int i = 0; i < nbits; i++) line[1 + i] = w[i];
    nline = 1 + nbits;
    if (par_on) begin
      line[nline] = exp_par;
      nline++;
    end
    for (int i = 0; i < stops; i++) begin
      line[nline] = 1'b1;
      nline++;
    end
    total = nline * CPB;

    checkOutput({tag, "_ready_pre"}, ready_v[d], 1);
    applyStimulus(d, 1'b1, w);
    @(negedge clk);
    if (!hold) applyStimulus(d, 1'b0, 9'h000);
    checkOutput({tag, "_tx_latency"}, tx_v[d], 1);
    checkOutput({tag, "_busy_latency"}, busy_v[d], 0);
    checkOutput({tag, "_ready_accepted"}, ready_v[d], 0);
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (glitch_k >= 0 && k == glitch_k) applyStimulus(d, 1'b1, 9'h1FF);
      else if (glitch_k >= 0 && k == glitch_k + 1) applyStimulus(d, 1'b0, 9'h000);
      checkOutput($sformatf("%s_tx_%0d", tag, k), tx_v[d], line[k / CPB]);
      checkOutput($sformatf("%s_busy_%0d", tag, k), busy_v[d], 1);
      checkOutput($sformatf("%s_done_%0d", tag, k), done_v[d], (k == total - 1) ? 1 : 0);
      checkOutput($sformatf("%s_ready_%0d", tag, k), ready_v[d], (k == total - 1) ? 1 : 0);
    end
  endtask

  task automatic idleCheck(input int d, input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_tx_%0d", tag, k), tx_v[d], 1);
      checkOutput($sformatf("%s_busy_%0d", tag, k), busy_v[d], 0);
      checkOutput($sformatf("%s_done_%0d", tag, k), done_v[d], 0);
      checkOutput($sformatf("%s_ready_%0d", tag, k), ready_v[d], 1);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) applyStimulus(d, 1'b0, 9'h000);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checkOutput($sformatf("reset_tx_%0d", d), tx_v[d], 1);
      checkOutput($sformatf("reset_busy_%0d", d), busy_v[d], 0);
      checkOutput($sformatf("reset_done_%0d", d), done_v[d], 0);
      checkOutput($sformatf("reset_ready_%0d", d), ready_v[d], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) checkOutput($sformatf("post_reset_ready_%0d", d), ready_v[d], 1);

    // 8N1 0xA5: 40-cycle frame then idle
    runFrame(0, "a5", 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b0, -1);
    idleCheck(0, "a5_post", 3);

    // 7-bit even / odd parity
    runFrame(1, "even07", 9'h007, 7, 1'b1, 1'b1, 1, 1'b0, -1);
    runFrame(1, "even03", 9'h003, 7, 1'b1, 1'b0, 1, 1'b0, -1);
    runFrame(2, "odd03",  9'h003, 7, 1'b1, 1'b1, 1, 1'b0, -1);
    idleCheck(2, "odd_post", 2);

    // two stop bits: 44-cycle frame
    runFrame(3, "stop2", 9'h0C3, 8, 1'b0, 1'b0, 2, 1'b0, -1);
    idleCheck(3, "stop2_post", 2);

    // held valid: second frame follows after one idle clock
    runFrame(0, "b2b_first",  9'h011, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    runFrame(0, "b2b_second", 9'h022, 8, 1'b0, 1'b0, 1, 1'b0, -1);
    idleCheck(0, "b2b_post", 2);

    // valid pulse while busy must be ignored
    runFrame(0, "glitch", 9'h081, 8, 1'b0, 1'b0, 1, 1'b0, 10);
    idleCheck(0, "glitch_post", 8);

    // reset in the middle of DATA abandons the frame
    applyStimulus(0, 1'b1, 9'h05A);
    @(negedge clk);
    applyStimulus(0, 1'b0, 9'h000);
    repeat (10) @(negedge clk);
    checkOutput("midreset_busy_before", busy_v[0], 1);
    rst_n = 1'b0;
    checkOutput("midreset_ready_low", ready_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midreset_tx", tx_v[0], 1);
    checkOutput("midreset_busy", busy_v[0], 0);
    checkOutput("midreset_done", done_v[0], 0);
    idleCheck(0, "midreset_idle", 40);
    runFrame(0, "fresh", 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0, -1);
    idleCheck(0, "fresh_post", 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
